// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default constants for the UART loopback block.
//   rx_state_t / tx_state_t : receive / transmit FSM states
//   DEF_*                   : default tick divisor, oversample ratio, data width
//                             and FIFO depth
package uart_pkg;

  localparam int DEF_CLKS_PER_TICK = 54;  // 100 MHz / 54 / 16 ~= 115200 baud
  localparam int DEF_OVERSAMPLE    = 16;
  localparam int DEF_DATA_BITS     = 8;
  localparam int DEF_FIFO_DEPTH    = 4;

  // Both enums live in one package, so the literals carry an RX_/TX_ prefix.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: small synchronous FIFO buffering received bytes for the
// transmitter.
//   clk       : system clock
//   reset     : asynchronous active-low reset (clears pointers -> empty)
//   push      : write push_data (ignored when full)
//   push_data : byte to store
//   pop       : consume the head entry (ignored when empty)
//   pop_data  : head entry, valid whenever empty=0
//   empty     : no entries stored
//   full      : FIFO_DEPTH entries stored
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH      = DEF_DATA_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign wr_en    = push & ~full;
  assign rd_en    = pop & ~empty;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage holds data only; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_loopback.sv
// uart_loopback: 8N1 UART echo endpoint. Every byte received on data_in is
// buffered and retransmitted unchanged on data_out, using a shared 16x
// oversample tick.
//   clk      : system clock (100 MHz nominal)
//   reset    : asynchronous active-low reset; aborts any frame in progress
//   data_in  : serial RX line, idle high, asynchronous to clk
//   data_out : serial TX line, idle high, driven from a register
module uart_loopback
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = DEF_CLKS_PER_TICK,
  parameter int OVERSAMPLE    = DEF_OVERSAMPLE,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic data_out
);

  localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

  // ---------------------------------------------------------------- tick
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  // ---------------------------------------------------------------- RX sync
  logic rx_meta_q;
  logic rx_sync_q;

  // An unknown line level is taken as idle (not low) so it can never start
  // a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= (data_in !== 1'b0);
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------- RX FSM
  rx_state_t            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q,   rx_cnt_d;
  logic [BW-1:0]        rx_bits_q,  rx_bits_d;
  logic                 rx_brk_q,   rx_brk_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_push;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_empty;
  logic                 fifo_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bits_q  <= '0;
      rx_brk_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bits_q  <= rx_bits_d;
      rx_brk_q   <= rx_brk_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bits_d  = rx_bits_q;
    rx_brk_d   = rx_brk_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        // After a framing error the line must go high again before a new
        // start bit is believed.
        if (rx_brk_q) begin
          if (rx_sync_q) rx_brk_d = 1'b0;
        end else if (tick && !rx_sync_q) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_d   = '0;
            rx_bits_d  = '0;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_cnt_q == FULL_LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            rx_bits_d  = rx_bits_q + BW'(1);
            if (rx_bits_q == BITS_LAST) rx_state_d = RX_STOP;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_cnt_q == FULL_LAST) begin
            // Leave at the mid-stop sample so a back-to-back start bit is
            // caught.
            rx_cnt_d   = '0;
            rx_state_d = RX_IDLE;
            if (rx_sync_q) rx_push  = 1'b1;
            else           rx_brk_d = 1'b1;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A byte arriving while the FIFO is full is dropped.
  assign fifo_push = rx_push & ~fifo_full;

  // ---------------------------------------------------------------- FIFO
  uart_sync_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (rx_shift_q),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // ---------------------------------------------------------------- TX FSM
  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q,   tx_cnt_d;
  logic [BW-1:0]        tx_bits_q,  tx_bits_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_out_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bits_q  <= '0;
      data_out   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bits_q  <= tx_bits_d;
      data_out   <= tx_out_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bits_d  = tx_bits_q;
    tx_shift_d = tx_shift_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tick && !fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_data;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          if (tx_cnt_q == FULL_LAST) begin
            tx_cnt_d   = '0;
            tx_bits_d  = '0;
            tx_state_d = TX_DATA;
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_cnt_q == FULL_LAST) begin
            tx_cnt_d   = '0;
            tx_shift_d = tx_shift_q >> 1;
            tx_bits_d  = tx_bits_q + BW'(1);
            if (tx_bits_q == BITS_LAST) tx_state_d = TX_STOP;
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_cnt_q == FULL_LAST) begin
            tx_cnt_d = '0;
            // A waiting byte follows immediately, with no idle bit between.
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              tx_shift_d = fifo_data;
              tx_state_d = TX_START;
            end else begin
              tx_state_d = TX_IDLE;
            end
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // The line level is decoded from the next state so the register changes
    // on the same edge as the FSM.
    case (tx_state_d)
      TX_START: tx_out_d = 1'b0;
      TX_DATA:  tx_out_d = tx_shift_d[0];
      default:  tx_out_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_loopback.sv
// tb_uart_loopback: directed bench for uart_loopback. A short tick divisor
// (4 clk/tick, 64 clk/bit) keeps frame times small; the serial monitor decodes
// every frame seen on data_out into queues for the main sequence to check.
module tb_uart_loopback;
  import uart_pkg::*;

  localparam int CPT    = 4;
  localparam int OS     = 16;
  localparam int BIT    = CPT * OS;   // clocks per bit
  localparam int BIT_NS = BIT * 10;   // 10 ns clock

  logic clk;
  logic reset;
  logic data_in;
  logic data_out;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mon_q[$];
  logic       mon_stop_q[$];
  int         mon_low_q[$];

  uart_loopback #(
    .CLKS_PER_TICK (CPT),
    .OVERSAMPLE    (OS),
    .DATA_BITS     (8),
    .FIFO_DEPTH    (4)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame decoder: k counts negedges from the first low sample of a start bit.
  initial begin
    logic [7:0] b;
    logic       stp;
    int         low;
    bit         run;
    forever begin
      @(negedge clk);
      if (data_out === 1'b0) begin
        b = '0; stp = 1'b0; low = 0; run = 1'b1;
        for (int k = 0; k <= 9*BIT + BIT/2; k++) begin
          if (k > 0) @(negedge clk);
          if (run && data_out === 1'b0) low++;
          else run = 1'b0;
          if (k >= BIT + BIT/2 && k < 9*BIT && ((k - BIT/2) % BIT) == 0)
            b[(k - BIT/2)/BIT - 1] = data_out;
          if (k == 9*BIT + BIT/2) stp = data_out;
        end
        mon_q.push_back(b);
        mon_stop_q.push_back(stp);
        mon_low_q.push_back(low);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    data_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      data_in = b[i];
      #(BIT_NS);
    end
    data_in = stop_bit;
    #(BIT_NS);
    data_in = 1'b1;
  endtask

  task automatic wait_frames(input int n, input int max_clks, input string tag);
    int i;
    i = 0;
    while (mon_q.size() < n && i < max_clks) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(mon_q.size() >= n), 32'd1);
  endtask

  task automatic clear_mon();
    mon_q.delete();
    mon_stop_q.delete();
    mon_low_q.delete();
  endtask

  initial begin
    logic [7:0] exp_b;
    data_in = 1'b1;
    reset   = 1'b1;
    #1 reset = 1'b0;

    // Reset state
    #1;
    chk("reset_data_out", 32'(data_out), 32'd1);
    chk("reset_fifo_empty", 32'(u_dut.u_fifo.empty), 32'd1);
    chk("reset_rx_idle", 32'(u_dut.rx_state_q), 32'(RX_IDLE));
    chk("reset_tx_idle", 32'(u_dut.tx_state_q), 32'(TX_IDLE));
    #10 reset = 1'b1;

    // Idle line produces nothing
    #(20*BIT_NS);
    chk("idle_data_out", 32'(data_out), 32'd1);
    chk("idle_no_frames", 32'(mon_q.size()), 32'd0);

    // Single byte 0x30: start + four zero bits = 5 bit times low
    send_byte(8'h30, 1'b1);
    wait_frames(1, 40*BIT, "single_timeout");
    chk("single_byte", 32'(mon_q[0]), 32'h30);
    chk("single_stop", 32'(mon_stop_q[0]), 32'd1);
    chk("single_low_run", 32'(mon_low_q[0]), 32'(5*BIT));
    clear_mon();

    // Sixteen back-to-back frames
    for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i), 1'b1);
    wait_frames(16, 60*BIT, "burst_timeout");
    chk("burst_count", 32'(mon_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      exp_b = 8'h30 + 8'(i);
      chk($sformatf("burst_byte%0d", i), 32'(mon_q[i]), 32'(exp_b));
      chk($sformatf("burst_stop%0d", i), 32'(mon_stop_q[i]), 32'd1);
    end
    clear_mon();

    // Three-tick glitch is rejected
    data_in = 1'b0;
    #(3*CPT*10);
    data_in = 1'b1;
    #(15*BIT_NS);
    chk("glitch_rx_idle", 32'(u_dut.rx_state_q), 32'(RX_IDLE));
    chk("glitch_no_frames", 32'(mon_q.size()), 32'd0);

    // Framing error drops 0x55; following 0xA5 is echoed
    send_byte(8'h55, 1'b0);
    #(2*BIT_NS);
    send_byte(8'hA5, 1'b1);
    wait_frames(1, 40*BIT, "ferr_timeout");
    chk("ferr_byte", 32'(mon_q[0]), 32'hA5);
    #(12*BIT_NS);
    chk("ferr_count", 32'(mon_q.size()), 32'd1);
    clear_mon();

    // Reset during the echo of 0x3C (during its bit 0, which is low)
    send_byte(8'h3C, 1'b1);
    #(BIT_NS);
    chk("tx_busy_before_reset", 32'(data_out), 32'd0);
    reset = 1'b0;
    #1;
    chk("midreset_data_out", 32'(data_out), 32'd1);
    chk("midreset_fifo_empty", 32'(u_dut.u_fifo.empty), 32'd1);
    chk("midreset_tx_idle", 32'(u_dut.tx_state_q), 32'(TX_IDLE));
    #99 reset = 1'b1;
    #(12*BIT_NS);
    chk("postreset_data_out", 32'(data_out), 32'd1);
    clear_mon();
    send_byte(8'h41, 1'b1);
    wait_frames(1, 40*BIT, "postreset_timeout");
    chk("postreset_byte", 32'(mon_q[0]), 32'h41);
    chk("postreset_stop", 32'(mon_stop_q[0]), 32'd1);
    chk("postreset_low_run", 32'(mon_low_q[0]), 32'(BIT));
    #(4*BIT_NS);
    chk("postreset_count", 32'(mon_q.size()), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
